// File: rtl/gpr_file_sb.sv
// gpr_file_sb: parametrised GPR file with per-register busy scoreboard.
// Two combinational read ports (Rs/Rt) and one writeback port. The write
// destination is LINK_REG for jal, otherwise Rd or Rt as selected by Rdst.
// A busy bit per register marks a pending producer: it is set at issue and
// cleared at writeback, and set wins when both hit the same register on one edge.
// Optional macro GPR_WRITE_BYPASS_EN adds same-cycle forwarding of busW
// (and of the clearing busy bit) to the read ports.
module gpr_file_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LINK_REG = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          regWr,
  input  logic [AW-1:0] Rs,
  input  logic [AW-1:0] Rt,
  input  logic [AW-1:0] Rd,
  input  logic          Rdst,
  input  logic          jal_instr,
  input  logic [DW-1:0] busW,
  output logic [DW-1:0] busA,
  output logic [DW-1:0] busB,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_dst,
  output logic          busyA,
  output logic          busyB,
  output logic [AW:0]   busy_cnt
);
  localparam int NREG = 2**AW;

  logic [DW-1:0] regs [NREG];
  logic [NREG-1:0] busy, busy_nxt;
  logic [AW:0]     cnt_nxt;
  logic [AW-1:0]   wdst;
  logic            wr_en;

  // Destination select: jal beats Rdst; writes to r0 are dropped
  assign wdst  = jal_instr ? AW'(LINK_REG) : (Rdst ? Rd : Rt);
  assign wr_en = regWr && (wdst != '0);

  // Register storage; r0 is never written so it stays at its reset value of 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wdst] <= busW;
    end
  end

  // Next scoreboard state: issue sets, writeback clears, set has priority
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int i = 1; i < NREG; i++) begin
      if (issue_valid && issue_dst == AW'(i))
        busy_nxt[i] = 1'b1;
      else if (regWr && wdst == AW'(i))
        busy_nxt[i] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
  end

  // Busy bits and their population count move together on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

`ifdef GPR_WRITE_BYPASS_EN
  logic byp_a, byp_b;
  assign byp_a = wr_en && (Rs == wdst);
  assign byp_b = wr_en && (Rt == wdst);

  // Forward the in-flight write; its busy bit reads as cleared unless re-issued
  always_comb begin
    busA  = byp_a ? busW : regs[Rs];
    busB  = byp_b ? busW : regs[Rt];
    busyA = byp_a ? (issue_valid && issue_dst == Rs) : busy[Rs];
    busyB = byp_b ? (issue_valid && issue_dst == Rt) : busy[Rt];
  end
`else
  // Plain registered-state reads
  always_comb begin
    busA  = regs[Rs];
    busB  = regs[Rt];
    busyA = busy[Rs];
    busyB = busy[Rt];
  end
`endif

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed testbench for gpr_file_sb (default parameters, DW=32, AW=5).
module tb_gpr_file_sb;
  logic        clk, reset, regWr, Rdst, jal_instr, issue_valid;
  logic [4:0]  Rs, Rt, Rd, issue_dst;
  logic [31:0] busW, busA, busB;
  logic        busyA, busyB;
  logic [5:0]  busy_cnt;

  int tests = 0;
  int fails = 0;

  gpr_file_sb #(.DW(32), .AW(5), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .regWr(regWr), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Rdst(Rdst), .jal_instr(jal_instr), .busW(busW), .busA(busA), .busB(busB),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .busyA(busyA),
    .busyB(busyB), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef GPR_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWr = 1'b0; jal_instr = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; regWr = 1'b1; Rdst = 1'b0; jal_instr = 1'b0;
    issue_valid = 1'b1; issue_dst = 5'd4;
    Rs = 5'd4; Rt = 5'd4; Rd = 5'd0; busW = 32'd80;

    // Reset held across several edges with write and issue active
    #100;
    chk("rst_busA", busA, 32'd0);
    chk("rst_busB", busB, 32'd0);
    chk("rst_busyA", {31'd0, busyA}, 32'd0);
    chk("rst_cnt", {26'd0, busy_cnt}, 32'd0);

    // Release; write r4 via Rt
    @(posedge clk); #1;
    reset = 1'b1; issue_valid = 1'b0;
    regWr = 1'b1; Rdst = 1'b0; Rt = 5'd4; Rs = 5'd4; busW = 32'd80;
    #1;
    chk("pre_edge_busA", busA, BYP ? 32'd80 : 32'd0);
    tick();
    chk("wr_r4_busA", busA, 32'd80);
    chk("wr_r4_busB", busB, 32'd80);
    Rs = 5'd4; Rt = 5'd3; busW = 32'd111;
    tick();
    idle();
    #1;
    chk("r4_hold", busA, 32'd80);
    chk("wr_r3", busB, 32'd111);
    chk("wb_nonbusy_cnt", {26'd0, busy_cnt}, 32'd0);

    // r0 write discarded, r0 issue ignored
    regWr = 1'b1; Rdst = 1'b1; Rd = 5'd0; busW = 32'hFFFF_FFFF;
    tick();
    idle(); Rs = 5'd0;
    #1;
    chk("r0_read", busA, 32'd0);
    issue_valid = 1'b1; issue_dst = 5'd0;
    tick();
    idle();
    #1;
    chk("r0_busy", {31'd0, busyA}, 32'd0);
    chk("r0_cnt", {26'd0, busy_cnt}, 32'd0);

    // jal forces LINK_REG over Rdst/Rd
    jal_instr = 1'b1; regWr = 1'b1; Rdst = 1'b1; Rd = 5'd7; busW = 32'h400;
    tick();
    idle(); Rs = 5'd31; Rt = 5'd7;
    #1;
    chk("jal_r31", busA, 32'h400);
    chk("jal_r7", busB, 32'd0);

    // Scoreboard set, set+clear collision, clear
    issue_valid = 1'b1; issue_dst = 5'd9;
    tick();
    idle(); Rs = 5'd9;
    #1;
    chk("iss9_busy", {31'd0, busyA}, 32'd1);
    chk("iss9_cnt", {26'd0, busy_cnt}, 32'd1);
    issue_valid = 1'b1; issue_dst = 5'd9;
    regWr = 1'b1; Rdst = 1'b1; Rd = 5'd9; busW = 32'd5;
    tick();
    idle();
    #1;
    chk("coll_busy", {31'd0, busyA}, 32'd1);
    chk("coll_cnt", {26'd0, busy_cnt}, 32'd1);
    chk("coll_data", busA, 32'd5);
    regWr = 1'b1; Rdst = 1'b1; Rd = 5'd9; busW = 32'd6;
    tick();
    idle();
    #1;
    chk("wb9_busy", {31'd0, busyA}, 32'd0);
    chk("wb9_cnt", {26'd0, busy_cnt}, 32'd0);
    chk("wb9_data", busA, 32'd6);

    // Fill the scoreboard
    for (int i = 1; i <= 31; i++) begin
      issue_valid = 1'b1; issue_dst = 5'(i);
      tick();
      if (i == 16) chk("fill16_cnt", {26'd0, busy_cnt}, 32'd16);
    end
    idle(); Rs = 5'd31; Rt = 5'd0;
    #1;
    chk("fill_cnt", {26'd0, busy_cnt}, 32'd31);
    chk("fill_busyA", {31'd0, busyA}, 32'd1);
    chk("fill_busyB", {31'd0, busyB}, 32'd0);

    // Same-cycle bypass behaviour (r12 holds 0 and is busy)
    regWr = 1'b1; Rdst = 1'b1; Rd = 5'd12; busW = 32'd55; Rs = 5'd12;
    #1;
    chk("byp_busA", busA, BYP ? 32'd55 : 32'd0);
    chk("byp_busyA", {31'd0, busyA}, BYP ? 32'd0 : 32'd1);
    tick();
    idle();
    #1;
    chk("r12_after", busA, 32'd55);
    chk("r12_cnt", {26'd0, busy_cnt}, 32'd30);

    // Asynchronous reset mid-run, away from any edge
    @(posedge clk); #3;
    Rt = 5'd31;
    reset = 1'b0;
    #1;
    chk("arst_busA", busA, 32'd0);
    chk("arst_busB", busB, 32'd0);
    chk("arst_busyB", {31'd0, busyB}, 32'd0);
    chk("arst_cnt", {26'd0, busy_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
